// File: rtl/data_mem_responder_if.sv
// Load/store port between a RISC-V MEM stage (master) and the data-memory
// responder (slave): request fields, load data and the completion handshake.
interface data_mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_dataout;
  logic [2:0]        funct3;
  logic [31:0]       d_datain;
  logic              mem_ack;
  logic              mem_err;
  logic              busy;

  modport master (
    output mem_req, mem_write, d_addr, d_dataout, funct3,
    input  d_datain, mem_ack, mem_err, busy
  );

  modport slave (
    input  mem_req, mem_write, d_addr, d_dataout, funct3,
    output d_datain, mem_ack, mem_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one little-endian byte/half/word access per request
// into a word array, answered by a single registered ack after WAIT_CYCLES.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  res_n,
  data_mem_responder_if.slave   bus
);

  localparam int         DEPTH    = 2 ** (ADDR_W - 2);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic [31:0]       d_datain_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;

  logic [31:0]       mem_q [DEPTH];

  // With no wait states the commit edge is the accept edge, so the access
  // must be decoded straight from the bus rather than from the latched copy.
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [2:0]        acc_f3;

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = bus.mem_write;
      acc_addr  = bus.d_addr;
      acc_wdata = bus.d_dataout;
      acc_f3    = bus.funct3;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_f3    = funct3_q;
    end
  end

  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;
  logic              f3_legal;
  logic              misaligned;
  logic              acc_err;
  logic              commit;
  logic              mem_we;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [31:0]       resp_data;
  logic [3:0]        byte_en;
  logic [31:0]       wr_lanes;

  assign word_idx = acc_addr[ADDR_W-1:2];
  assign lane     = acc_addr[1:0];
  assign rd_word  = mem_q[word_idx];
  assign rd_byte  = rd_word[8*lane +: 8];
  assign rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  assign f3_legal   = acc_write ? (acc_f3 inside {3'b000, 3'b001, 3'b010})
                                : (acc_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                      ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
  assign acc_err    = !f3_legal || misaligned;

  // Reset gates the commit so an abort on the same edge can never write.
  assign commit = res_n &&
                  ((NO_WAIT && (state_q == S_IDLE) && bus.mem_req) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd0)));
  assign mem_we = commit && acc_write && !acc_err;

  always_comb begin
    load_val = 32'd0;
    byte_en  = 4'b0000;
    wr_lanes = acc_wdata;
    unique case (acc_f3)
      3'b000: begin
        load_val = {{24{rd_byte[7]}}, rd_byte};
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{acc_wdata[7:0]}};
      end
      3'b001: begin
        load_val = {{16{rd_half[15]}}, rd_half};
        byte_en  = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{acc_wdata[15:0]}};
      end
      3'b010: begin
        load_val = rd_word;
        byte_en  = 4'b1111;
      end
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

  assign resp_data = (acc_err || acc_write) ? 32'd0 : load_val;

  // NOTE: the storage array has no reset branch; clearing 64 words on reset
  // would turn the RAM into flops and its contents must survive reset anyway.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && byte_en[i]) begin
        mem_q[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      d_datain_q <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      d_datain_q <= 32'd0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.mem_req) begin
            write_q  <= bus.mem_write;
            addr_q   <= bus.d_addr;
            wdata_q  <= bus.d_dataout;
            funct3_q <= bus.funct3;
            busy_q   <= 1'b1;
            if (NO_WAIT) begin
              state_q    <= S_RESP;
              ack_q      <= 1'b1;
              err_q      <= acc_err;
              d_datain_q <= resp_data;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q    <= S_RESP;
            ack_q      <= 1'b1;
            err_q      <= acc_err;
            d_datain_q <= resp_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d_datain = d_datain_q;
  assign bus.mem_ack  = ack_q;
  assign bus.mem_err  = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=1 instance for data,
// alignment, error and reset-abort checks, and a WAIT_CYCLES=3 instance for timing.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic res1_n = 1'b0;
  logic res3_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(8)) bus1 ();
  data_mem_responder_if #(.ADDR_W(8)) bus3 ();

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut (
    .clk   (clk),
    .res_n (res1_n),
    .bus   (bus1.slave)
  );

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
    .clk   (clk),
    .res_n (res3_n),
    .bus   (bus3.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the WAIT_CYCLES=1 port; starts and ends at posedge+1 in IDLE.
  task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_err);
    exp_t got;
    int   cyc;
    sb.push_back('{data: exp_data, err: exp_err});
    bus1.mem_write = wr;
    bus1.funct3    = f3;
    bus1.d_addr    = addr;
    bus1.d_dataout = wdata;
    bus1.mem_req   = 1'b1;
    tick();
    check({tag, "_busy"}, 32'(bus1.busy), 32'd1);
    cyc = 1;
    while (!bus1.mem_ack && cyc < 20) begin
      tick();
      cyc++;
    end
    bus1.mem_req = 1'b0;
    check({tag, "_ack_cycle"}, 32'(cyc), 32'd2);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check({tag, "_data"}, bus1.d_datain, got.data);
      check({tag, "_err"}, 32'(bus1.mem_err), 32'(got.err));
    end
    tick();
    check({tag, "_idle_ack"}, {29'd0, bus1.mem_ack, bus1.mem_err, bus1.busy}, 32'd0);
    check({tag, "_idle_data"}, bus1.d_datain, 32'd0);
  endtask

  initial begin
    exp_t got;
    bus1.mem_req = 1'b0; bus1.mem_write = 1'b0; bus1.d_addr = '0;
    bus1.d_dataout = '0; bus1.funct3 = '0;
    bus3.mem_req = 1'b0; bus3.mem_write = 1'b0; bus3.d_addr = '0;
    bus3.d_dataout = '0; bus3.funct3 = '0;

    // Reset state
    tick();
    check("rst_outs1", {29'd0, bus1.mem_ack, bus1.mem_err, bus1.busy}, 32'd0);
    check("rst_data1", bus1.d_datain, 32'd0);
    check("rst_outs3", {29'd0, bus3.mem_ack, bus3.mem_err, bus3.busy}, 32'd0);
    res1_n = 1'b1;
    res3_n = 1'b1;
    tick();

    // Word store then load
    do_access("sw_10", 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_access("lw_10", 1'b0, 3'b010, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store and sign/zero-extended byte loads
    do_access("sb_11",  1'b1, 3'b000, 8'h11, 32'h00000080, 32'h0, 1'b0);
    do_access("lb_11",  1'b0, 3'b000, 8'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    do_access("lbu_11", 1'b0, 3'b100, 8'h11, 32'h0, 32'h00000080, 1'b0);
    do_access("lw_10b", 1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD80EF, 1'b0);

    // Halfword store and halfword loads
    do_access("sh_12",  1'b1, 3'b001, 8'h12, 32'hFFFF1234, 32'h0, 1'b0);
    do_access("lhu_12", 1'b0, 3'b101, 8'h12, 32'h0, 32'h00001234, 1'b0);
    do_access("lh_10",  1'b0, 3'b001, 8'h10, 32'h0, 32'hFFFF80EF, 1'b0);
    do_access("lw_10c", 1'b0, 3'b010, 8'h10, 32'h0, 32'h123480EF, 1'b0);

    // Error cases leave the array untouched
    do_access("lw_mis13", 1'b0, 3'b010, 8'h13, 32'h0, 32'h0, 1'b1);
    do_access("sw_mis12", 1'b1, 3'b010, 8'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_access("st_f3_011", 1'b1, 3'b011, 8'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_access("ld_f3_110", 1'b0, 3'b110, 8'h10, 32'h0, 32'h0, 1'b1);
    do_access("lh_mis11", 1'b0, 3'b001, 8'h11, 32'h0, 32'h0, 1'b1);
    do_access("lw_10d", 1'b0, 3'b010, 8'h10, 32'h0, 32'h123480EF, 1'b0);

    // WAIT_CYCLES=3 with mem_req held high through the ack cycle
    sb.push_back('{data: 32'h0, err: 1'b0});
    bus3.mem_write = 1'b1;
    bus3.funct3    = 3'b010;
    bus3.d_addr    = 8'h04;
    bus3.d_dataout = 32'hCAFEF00D;
    bus3.mem_req   = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("w3_busy_c%0d", c), 32'(bus3.busy), 32'd1);
      check($sformatf("w3_ack_c%0d", c), 32'(bus3.mem_ack), 32'(c == 4));
      if (bus3.mem_ack && sb.size() != 0) begin
        got = sb.pop_front();
        check("w3_data", bus3.d_datain, got.data);
        check("w3_err", 32'(bus3.mem_err), 32'(got.err));
      end
      if (c == 4) bus3.mem_req = 1'b0;
      tick();
    end
    check("w3_idle", {29'd0, bus3.mem_ack, bus3.mem_err, bus3.busy}, 32'd0);
    tick();
    check("w3_no_reaccept", 32'(bus3.busy), 32'd0);

    // Reset in WAIT aborts a store; the prior word survives
    do_access("sw_20", 1'b1, 3'b010, 8'h20, 32'h11223344, 32'h0, 1'b0);
    bus1.mem_write = 1'b1;
    bus1.funct3    = 3'b010;
    bus1.d_addr    = 8'h20;
    bus1.d_dataout = 32'h55AA55AA;
    bus1.mem_req   = 1'b1;
    tick();
    check("abort_busy_pre", 32'(bus1.busy), 32'd1);
    #2;
    res1_n = 1'b0;
    #1;
    check("abort_outs", {29'd0, bus1.mem_ack, bus1.mem_err, bus1.busy}, 32'd0);
    check("abort_data", bus1.d_datain, 32'd0);
    bus1.mem_req = 1'b0;
    tick();
    check("abort_no_ack1", 32'(bus1.mem_ack), 32'd0);
    tick();
    check("abort_no_ack2", 32'(bus1.mem_ack), 32'd0);
    res1_n = 1'b1;
    tick();
    check("abort_post_idle", {29'd0, bus1.mem_ack, bus1.mem_err, bus1.busy}, 32'd0);
    do_access("lw_20", 1'b0, 3'b010, 8'h20, 32'h0, 32'h11223344, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
